// File: rtl/cache_mem_arbiter.sv
// Single-port memory arbiter between the I-cache fill path and the D-cache fill/writeback path.
// Optional ARB_ROUND_ROBIN_EN: contested grants alternate against the last-grant register.
`timescale 1ns/1ps
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy,
  output logic              arb_grant_d
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic                side_d_q, side_d_d;
  logic                last_d_q, last_d_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_req;
  logic                pick_d;
  logic                serving;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Contested: take the side opposite the last grant; uncontested: take whoever asks.
  assign pick_d = d_req & (~i_read | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    side_d_d  = side_d_q;
    last_d_d  = last_d_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_req || i_read) begin
          side_d_d = pick_d;
          addr_d   = pick_d ? d_addr : i_addr;
          wdata_d  = pick_d ? d_wdata : '0;
          wr_d     = pick_d & d_write;
          state_d  = pick_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          if (!wr_q) begin
            if (side_d_q) d_rdata_d = pmem_rdata;
            else          i_rdata_d = pmem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        last_d_d = side_d_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      side_d_q  <= 1'b0;
      last_d_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      side_d_q  <= side_d_d;
      last_d_q  <= last_d_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Strobes decode straight from state, so an async reset drops them without a clock.
  assign serving     = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read   = serving & ~wr_q;
  assign pmem_write  = serving & wr_q;
  assign pmem_addr   = addr_q;
  assign pmem_wdata  = wdata_q;
  assign i_resp      = (state_q == DONE) & ~side_d_q;
  assign d_resp      = (state_q == DONE) & side_d_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign arb_busy    = (state_q != IDLE);
  assign arb_grant_d = arb_busy ? side_d_q : last_d_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboarded bench for cache_mem_arbiter: directed cases, then random I/D traffic
// against a behavioural memory model. Honours ARB_ROUND_ROBIN_EN for grant-order expectations.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              arb_busy, arb_grant_d;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy), .arb_grant_d(arb_grant_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: an address never written holds a pattern derived from its address.
  function automatic logic [LINE_W-1:0] mem_default(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // Environment memory (behind pmem) and independent reference image (updated at issue time).
  logic [LINE_W-1:0] pmem_arr [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] d_model_rdata = '0;

  function automatic logic [LINE_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [LINE_W-1:0] wdata;
    logic              gd;
  } op_t;
  op_t op_log[$];

  logic [LINE_W-1:0] i_exp_q[$];
  logic [LINE_W-1:0] d_exp_q[$];

  // pmem responder: fixed_delay >= 0 forces the wait, otherwise random 0..3 cycles.
  int fixed_delay = -1;
  int wait_cnt;
  bit active;
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    wait_cnt   = 0;
    active     = 1'b0;
    forever begin
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = {8{$urandom}};
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if ((pmem_read || pmem_write) && !active) begin
        active   = 1'b1;
        op_log.push_back('{addr: pmem_addr, wr: pmem_write, wdata: pmem_wdata, gd: arb_grant_d});
        wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end
      if (active) begin
        if (wait_cnt == 0) begin
          if (pmem_write) pmem_arr[pmem_addr] = pmem_wdata;
          else pmem_rdata = pmem_arr.exists(pmem_addr) ? pmem_arr[pmem_addr] : mem_default(pmem_addr);
          pmem_resp = 1'b1;
          active    = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: scoreboard pops plus protocol rules on the pmem side.
  logic              presp_edge = 1'b0;
  logic              prev_strobe = 1'b0, prev_wr = 1'b0, prev_i_resp = 1'b0, prev_d_resp = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [LINE_W-1:0] prev_wdata = '0;
  int                gap = 2;

  always @(posedge clk) presp_edge <= rst_n && pmem_resp && (pmem_read || pmem_write);

  always @(negedge clk) begin
    if (rst_n) begin
      if (i_resp && d_resp) check("both_resp", 1'b1, 1'b0);
      if (i_resp || d_resp || presp_edge) check("resp_latency", i_resp | d_resp, presp_edge);
      if (i_resp && prev_i_resp) check("i_resp_width", 1'b1, 1'b0);
      if (d_resp && prev_d_resp) check("d_resp_width", 1'b1, 1'b0);
      if (i_resp) begin
        if (i_exp_q.size() == 0) check("i_resp_unexpected", 1'b1, 1'b0);
        else check("i_rdata", i_rdata, i_exp_q.pop_front());
      end
      if (d_resp) begin
        if (d_exp_q.size() == 0) check("d_resp_unexpected", 1'b1, 1'b0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
      if (pmem_read && pmem_write) check("both_strobes", 1'b1, 1'b0);
      if ((pmem_read || pmem_write) && prev_strobe) begin
        if (pmem_addr !== prev_addr)   check("addr_stable", pmem_addr, prev_addr);
        if (pmem_wdata !== prev_wdata) check("wdata_stable", pmem_wdata, prev_wdata);
        if (pmem_write !== prev_wr)    check("op_stable", pmem_write, prev_wr);
      end
      if ((pmem_read || pmem_write) && !prev_strobe) check("strobe_gap_ok", gap >= 2, 1'b1);
    end
    gap         = (pmem_read || pmem_write) ? 0 : gap + 1;
    prev_strobe = pmem_read | pmem_write;
    prev_wr     = pmem_write;
    prev_addr   = pmem_addr;
    prev_wdata  = pmem_wdata;
    prev_i_resp = i_resp;
    prev_d_resp = d_resp;
  end

  task automatic i_req(input logic [ADDR_W-1:0] a);
    bit done = 0;
    i_read = 1'b1;
    i_addr = a;
    i_exp_q.push_back(ref_read(a));
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (i_resp) done = 1;
      else if (arb_busy && !arb_grant_d) i_addr = $urandom;
    end
    if (!done) check("i_timeout", 1'b1, 1'b0);
    i_read = 1'b0;
  endtask

  task automatic d_req(input logic [ADDR_W-1:0] a, input logic rd, input logic wr,
                       input logic [LINE_W-1:0] wd);
    bit done = 0;
    d_read  = rd;
    d_write = wr;
    d_addr  = a;
    d_wdata = wd;
    if (wr) begin
      ref_mem[a] = wd;
    end else begin
      d_model_rdata = ref_read(a);
    end
    d_exp_q.push_back(d_model_rdata);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (d_resp) done = 1;
      else if (arb_busy && arb_grant_d) begin
        d_addr  = $urandom;
        d_wdata = {8{$urandom}};
      end
    end
    if (!done) check("d_timeout", 1'b1, 1'b0);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  initial begin
    logic [LINE_W-1:0] wb_data;
    bit seen;
    rst_n = 1'b0; i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_addr", pmem_addr, '0);
    check("rst_resp", {i_resp, d_resp}, 2'b00);
    check("rst_busy", arb_busy, 1'b0);
    check("rst_grant_d", arb_grant_d, 1'b0);
    check("rst_i_rdata", i_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone I-fill with a 2-cycle memory response.
    pmem_arr[32'h60] = {32{8'hA5}};
    ref_mem[32'h60]  = {32{8'hA5}};
    fixed_delay = 2;
    op_log.delete();
    i_req(32'h0000_0060);
    check("ifill_ops", op_log.size(), 1);
    if (op_log.size() >= 1) begin
      check("ifill_addr", op_log[0].addr, 32'h60);
      check("ifill_op", op_log[0].wr, 1'b0);
    end

    // D writeback; address and data scribbled while being served.
    wb_data = {8{32'h1234_5678}};
    op_log.delete();
    d_req(32'h0000_1000, 1'b0, 1'b1, wb_data);
    check("wb_ops", op_log.size(), 1);
    if (op_log.size() >= 1) begin
      check("wb_addr", op_log[0].addr, 32'h1000);
      check("wb_op", op_log[0].wr, 1'b1);
      check("wb_wdata", op_log[0].wdata, wb_data);
    end
    check("wb_mem", pmem_arr.exists(32'h1000) ? pmem_arr[32'h1000] : '0, wb_data);

    // Simultaneous requests; last grant is D here.
    op_log.delete();
    fork
      i_req(32'h0000_0080);
      d_req(32'h0001_0040, 1'b1, 1'b0, '0);
    join
    check("simul_ops", op_log.size(), 2);
    if (op_log.size() >= 2) begin
`ifdef ARB_ROUND_ROBIN_EN
      check("simul_first_addr", op_log[0].addr, 32'h0000_0080);
      check("simul_first_gd", op_log[0].gd, 1'b0);
      check("simul_second_addr", op_log[1].addr, 32'h0001_0040);
      check("simul_second_gd", op_log[1].gd, 1'b1);
`else
      check("simul_first_addr", op_log[0].addr, 32'h0001_0040);
      check("simul_first_gd", op_log[0].gd, 1'b1);
      check("simul_second_addr", op_log[1].addr, 32'h0000_0080);
      check("simul_second_gd", op_log[1].gd, 1'b0);
`endif
    end

    // Illegal read+write: write wins.
    op_log.delete();
    d_req(32'h0001_0060, 1'b1, 1'b1, {8{32'hCAFE_F00D}});
    check("both_op_ops", op_log.size(), 1);
    if (op_log.size() >= 1) check("both_op_wr", op_log[0].wr, 1'b1);

    // Reset mid-SERVE_D.
    fixed_delay = 3;
    d_read = 1'b1;
    d_addr = 32'h0001_0020;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (pmem_read) seen = 1;
    end
    check("rst_mid_strobe_seen", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_pmem_read", pmem_read, 1'b0);
    check("rst_mid_busy", arb_busy, 1'b0);
    check("rst_mid_d_resp", d_resp, 1'b0);
    check("rst_mid_d_rdata", d_rdata, '0);
    check("rst_mid_grant_d", arb_grant_d, 1'b0);
    d_read = 1'b0;
    d_model_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fixed_delay = 0;
    d_req(32'h0001_0020, 1'b1, 1'b0, '0);

    // Random mixed traffic.
    fixed_delay = -1;
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          i_req(32'($urandom_range(0, 63)) << 5);
        end
      end
      begin
        repeat (40) begin
          logic [1:0] op;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          op = 2'($urandom_range(1, 3));
          d_req(32'h0001_0000 | (32'($urandom_range(0, 7)) << 5), op[0], op[1], {8{$urandom}});
        end
      end
    join
    repeat (5) @(negedge clk);
    check("i_queue_drained", i_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
